hdmi_video_timing: RTL

//   Lock-qualified video timing generator in the HDMI pixel-clock domain (PLL clkout0, 74.25 MHz for 720p60).

---
 rtl/hdmi_video_timing_if.sv | 20 ++
 rtl/hdmi_video_timing.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/hdmi_video_timing_if.sv
// Video timing bundle from the HDMI pixel-clock timing generator to the renderer and TMDS encoder.
`timescale 1ns/1ps
interface hdmi_video_timing_if;
  logic        video_ready;
  logic        hs;
  logic        vs;
  logic        de;
  logic [11:0] x;
  logic [11:0] y;
  logic        line_start;
  logic        frame_start;

  modport master (
    output video_ready, hs, vs, de, x, y, line_start, frame_start
  );

  modport slave (
    input video_ready, hs, vs, de, x, y, line_start, frame_start
  );
endinterface

// File: rtl/hdmi_video_timing.sv
// Lock-qualified video timing generator: waits for a stable synchronised PLL lock,
// then emits registered hs/vs/de and pixel coordinates, dropping back to idle on lock loss.
`timescale 1ns/1ps
module hdmi_video_timing #(
  parameter int unsigned H_ACTIVE  = 1280,
  parameter int unsigned H_FP      = 110,
  parameter int unsigned H_SYNC    = 40,
  parameter int unsigned H_BP      = 220,
  parameter int unsigned V_ACTIVE  = 720,
  parameter int unsigned V_FP      = 5,
  parameter int unsigned V_SYNC    = 5,
  parameter int unsigned V_BP      = 20,
  parameter bit          HS_POL    = 1'b1,
  parameter bit          VS_POL    = 1'b1,
  parameter int unsigned LOCK_WAIT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pll_lock,
  hdmi_video_timing_if.master  vid
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned CW      = 12;
  localparam int unsigned SW      = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;

  // Decode bounds carry one extra bit so a boundary equal to 4096 still compares correctly.
  localparam logic [CW:0]   H_ACT_END = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0]   HS_BEG    = (CW+1)'(H_ACTIVE + H_FP);
  localparam logic [CW:0]   HS_END    = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0]   V_ACT_END = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0]   VS_BEG    = (CW+1)'(V_ACTIVE + V_FP);
  localparam logic [CW:0]   VS_END    = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] H_LAST    = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST    = CW'(V_TOTAL - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(LOCK_WAIT - 1);

  if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_total_too_big
    $error("hdmi_video_timing: H_TOTAL and V_TOTAL must not exceed 4096");
  end
  if (LOCK_WAIT < 1) begin : g_lock_wait_zero
    $error("hdmi_video_timing: LOCK_WAIT must be at least 1");
  end

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t          state;
  logic            lock_m;
  logic            lock_s;
  logic [SW-1:0]   settle_cnt;
  logic [CW-1:0]   h_cnt;
  logic [CW-1:0]   v_cnt;

  logic            video_ready_q;
  logic            hs_q;
  logic            vs_q;
  logic            de_q;
  logic [CW-1:0]   x_q;
  logic [CW-1:0]   y_q;
  logic            line_start_q;
  logic            frame_start_q;

  logic            run_c;
  logic            h_act_c;
  logic            v_act_c;
  logic            hs_on_c;
  logic            vs_on_c;

  // Two-flop synchroniser for the asynchronous PLL lock.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= pll_lock;
      lock_s <= lock_m;
    end
  end

  // Lock qualification: any drop of lock_s restarts the full settle wait.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= WAIT_LOCK;
      settle_cnt <= '0;
    end else begin
      case (state)
        WAIT_LOCK: begin
          if (lock_s) begin
            state      <= SETTLE;
            settle_cnt <= '0;
          end
        end
        SETTLE: begin
          if (!lock_s) begin
            state <= WAIT_LOCK;
          end else if (settle_cnt == SETTLE_LAST) begin
            state <= RUN;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        RUN: begin
          if (!lock_s) begin
            state <= WAIT_LOCK;
          end
        end
        default: state <= WAIT_LOCK;
      endcase
    end
  end

  assign run_c = (state == RUN);

  // Raster counters run only in RUN and sit at the origin otherwise.
  always_ff @(posedge clk) begin
    if (rst || !run_c) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign h_act_c = ({1'b0, h_cnt} <  H_ACT_END);
  assign v_act_c = ({1'b0, v_cnt} <  V_ACT_END);
  assign hs_on_c = ({1'b0, h_cnt} >= HS_BEG) && ({1'b0, h_cnt} < HS_END);
  assign vs_on_c = ({1'b0, v_cnt} >= VS_BEG) && ({1'b0, v_cnt} < VS_END);

  // Outputs trail the counters by one cycle; v_cnt only moves at h wrap, so vs toggles at x==0.
  always_ff @(posedge clk) begin
    if (rst || !run_c) begin
      video_ready_q <= 1'b0;
      hs_q          <= ~HS_POL;
      vs_q          <= ~VS_POL;
      de_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      video_ready_q <= 1'b1;
      hs_q          <= hs_on_c ? HS_POL : ~HS_POL;
      vs_q          <= vs_on_c ? VS_POL : ~VS_POL;
      de_q          <= h_act_c && v_act_c;
      x_q           <= h_cnt;
      y_q           <= v_cnt;
      line_start_q  <= (h_cnt == '0);
      frame_start_q <= (h_cnt == '0) && (v_cnt == '0);
    end
  end

  assign vid.video_ready = video_ready_q;
  assign vid.hs          = hs_q;
  assign vid.vs          = vs_q;
  assign vid.de          = de_q;
  assign vid.x           = x_q;
  assign vid.y           = y_q;
  assign vid.line_start  = line_start_q;
  assign vid.frame_start = frame_start_q;

endmodule
